// File: rtl/twiddle_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_gen_pkg
//  Brief    : Shared constants and the elaboration-time sine helper for the
//             FFT twiddle-factor generator.
//  Revision : 1.0  initial release
// ============================================================================
package twiddle_gen_pkg;

    // Default packed twiddle width: two signed Q1.15 halves
    localparam int c_twiddle_width_default = 32;

    // Q1.15 full-scale value; -32768 is never produced so negation is safe
    localparam int c_q15_scale = 32767;

    // Width of the stage-index input
    localparam int c_stage_w = 4;

    // round(c_q15_scale * sin(2*pi*idx/n)) for 0 <= idx <= n/4.
    // A Taylor series keeps the ROM contents a pure elaboration-time
    // constant; the angle never exceeds pi/2, so twelve terms are far
    // below one LSB of error.
    function automatic int sine_q15(input int idx, input int n);
        real x;
        real term;
        real sum;
        x    = 2.0 * 3.14159265358979323846 * real'(idx) / real'(n);
        term = x;
        sum  = x;
        for (int j = 1; j < 12; j++) begin
            term = -term * x * x / real'((2 * j) * (2 * j + 1));
            sum  = sum + term;
        end
        return $rtoi(sum * real'(c_q15_scale) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_rom.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_rom
//  Brief    : Quarter-wave sine ROM, N/4+1 entries, two synchronous read
//             ports (one for the cosine lookup, one for the sine lookup).
//  Revision : 1.0  initial release
// ============================================================================
module twiddle_rom
    import twiddle_gen_pkg::*;
#(
    parameter int N      = 1024,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr_cos,
    input  logic [ADDR_W-1:0] addr_sin,
    output logic [DATA_W-1:0] data_cos,
    output logic [DATA_W-1:0] data_sin
);

    localparam int c_depth = N / 4 + 1;

    logic [DATA_W-1:0] w_rom [0:c_depth-1];

    // Each entry is a constant computed at elaboration
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
        localparam logic [DATA_W-1:0] c_val = DATA_W'(sine_q15(gi, N));
        assign w_rom[gi] = c_val;
    end

    // Registered read, stalls together with the rest of the pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_cos <= '0;
            data_sin <= '0;
        end else if (en) begin
            data_cos <= w_rom[addr_cos];
            data_sin <= w_rom[addr_sin];
        end
    end

endmodule
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_gen
//  Brief    : Streams W_N^m twiddles (m = k << stage) for one FFT butterfly
//             stage over a valid/ready handshake. Quarter-wave ROM lookup is
//             expanded by symmetry; optional conjugation for inverse FFT.
//             Pipeline: address reg -> ROM data reg -> output reg.
//  Revision : 1.0  initial release
// ============================================================================
module twiddle_gen
    import twiddle_gen_pkg::*;
#(
    parameter int N             = 1024,
    parameter int LOG2N         = 10,
    parameter int TWIDDLE_WIDTH = c_twiddle_width_default
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [c_stage_w-1:0]         stage,
    input  logic                         inverse,
    input  logic                         tw_ready,
    output logic                         tw_valid,
    output logic [TWIDDLE_WIDTH/2-1:0]   twiddle_real,
    output logic [TWIDDLE_WIDTH/2-1:0]   twiddle_imag,
    output logic                         tw_last,
    output logic                         busy
);

    localparam int c_hw   = TWIDDLE_WIDTH / 2;
    localparam int c_iw   = LOG2N - 1;
    localparam int c_half = N / 2;

    localparam logic [LOG2N-1:0] c_quarter_m = LOG2N'(N / 4);
    localparam logic [LOG2N-1:0] c_half_m    = LOG2N'(N / 2);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]            r_state;
    logic [c_stage_w-1:0]  r_stage;
    logic                  r_inv;
    logic [LOG2N-1:0]      r_k;
    logic                  r_busy;

    logic                  r_a_valid;
    logic                  r_a_last;
    logic                  r_a_neg;
    logic [c_iw-1:0]       r_a_cos_idx;
    logic [c_iw-1:0]       r_a_sin_idx;

    logic                  r_b_valid;
    logic                  r_b_last;
    logic                  r_b_neg;
    logic [c_hw-1:0]       w_rom_cos;
    logic [c_hw-1:0]       w_rom_sin;

    logic                  w_en;
    logic                  w_issue;
    logic [LOG2N-1:0]      w_k_last;
    logic [LOG2N-1:0]      w_m;
    logic [c_iw-1:0]       w_cos_idx;
    logic [c_iw-1:0]       w_sin_idx;
    logic                  w_cos_neg;

    // Whole pipeline and counter advance together; stall only on a held output
    assign w_en     = !tw_valid || tw_ready;
    assign w_issue  = (r_state == c_st_run);
    assign w_k_last = LOG2N'((c_half >> r_stage) - 1);
    assign w_m      = r_k << r_stage;
    assign busy     = r_busy;

    // Fold the half-circle angle index onto the quarter-wave table
    always_comb begin
        w_cos_idx = '0;
        w_sin_idx = '0;
        w_cos_neg = 1'b0;
        if (w_m <= c_quarter_m) begin
            w_cos_idx = c_iw'(c_quarter_m - w_m);
            w_sin_idx = c_iw'(w_m);
            w_cos_neg = 1'b0;
        end else begin
            w_cos_idx = c_iw'(w_m - c_quarter_m);
            w_sin_idx = c_iw'(c_half_m - w_m);
            w_cos_neg = 1'b1;
        end
    end

    // Sequence control: accept start, count k, wait for final acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_stage <= '0;
            r_inv   <= 1'b0;
            r_k     <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start && (int'(stage) < LOG2N)) begin
                        r_state <= c_st_run;
                        r_stage <= stage;
                        r_inv   <= inverse;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (w_en) begin
                        if (r_k == w_k_last) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    if (tw_valid && tw_ready && tw_last) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Address stage: register table indices and sign/last flags for index k
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid   <= 1'b0;
            r_a_last    <= 1'b0;
            r_a_neg     <= 1'b0;
            r_a_cos_idx <= '0;
            r_a_sin_idx <= '0;
        end else if (w_en) begin
            r_a_valid   <= w_issue;
            r_a_last    <= w_issue && (r_k == w_k_last);
            r_a_neg     <= w_cos_neg;
            r_a_cos_idx <= w_cos_idx;
            r_a_sin_idx <= w_sin_idx;
        end
    end

    twiddle_rom #(
        .N      (N),
        .ADDR_W (c_iw),
        .DATA_W (c_hw)
    ) u_rom (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_en),
        .addr_cos (r_a_cos_idx),
        .addr_sin (r_a_sin_idx),
        .data_cos (w_rom_cos),
        .data_sin (w_rom_sin)
    );

    // Data stage: carry control flags alongside the ROM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_last  <= 1'b0;
            r_b_neg   <= 1'b0;
        end else if (w_en) begin
            r_b_valid <= r_a_valid;
            r_b_last  <= r_a_last;
            r_b_neg   <= r_a_neg;
        end
    end

    // Output stage: apply cosine sign and forward/inverse sine sign
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tw_valid     <= 1'b0;
            tw_last      <= 1'b0;
            twiddle_real <= '0;
            twiddle_imag <= '0;
        end else if (w_en) begin
            tw_valid <= r_b_valid;
            tw_last  <= r_b_last;
            if (r_b_valid) begin
                twiddle_real <= r_b_neg ? -w_rom_cos : w_rom_cos;
                twiddle_imag <= r_inv   ?  w_rom_sin : -w_rom_sin;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Twiddle-factor source for one FFT butterfly stage. It streams the W_N^m sequence that the stage's complex multiplier consumes, using a valid/ready handshake. Factors are read from a quarter-wave sine ROM and expanded by symmetry, with optional conjugation for inverse FFT. Output format is Q1.15 real/imag halves, matching the multiplier's twiddle inputs (TWIDDLE_WIDTH/2 bits each).

Parameters:
N, 1024, FFT size (power of 2, >= 8)
LOG2N, 10, log2(N)
TWIDDLE_WIDTH, 32, packed twiddle width; each component is TWIDDLE_WIDTH/2 signed bits, Q1.15

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a sequence; sampled only when busy=0
stage  in  4  stage index s, 0..LOG2N-1; latched at start
inverse  in  1  1 = conjugate output (IFFT); latched at start
tw_ready  in  1  consumer accepts the current twiddle
tw_valid  out  1  twiddle_real/imag valid
twiddle_real  out  TWIDDLE_WIDTH/2  cos(2*pi*m/N), signed Q1.15
twiddle_imag  out  TWIDDLE_WIDTH/2  -sin (forward) or +sin (inverse), signed Q1.15
tw_last  out  1  high with the final twiddle of the sequence
busy  out  1  sequence in progress, including pipeline drain

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. While rst_n=0 at a clk edge, all state clears: tw_valid=0, tw_last=0, busy=0, twiddle_real=0, twiddle_imag=0, counter=0, FSM=IDLE. This applies mid-sequence too; the partial sequence is discarded.
- Sequence for stage s: K = N >> (s+1) twiddles, k = 0..K-1, angle index m = k << s, so m ranges over [0, N/2).
- ROM (twiddle_rom): N/4+1 entries, T[i] = round(32767*sin(2*pi*i/N)), i = 0..N/4. T[N/4] = 32767. Read is registered, 1 cycle.
- Symmetry mapping:
  - m <= N/4: cos = T[N/4-m], sin = T[m].
  - m > N/4: cos = -T[m-N/4], sin = T[N/2-m].
  - No -32768 values are produced, so negation never overflows.
- Output: twiddle_real = cos; twiddle_imag = inverse ? sin : -sin.
- FSM:
  - IDLE: start=1 and stage < LOG2N → RUN. Latch stage and inverse, set k=0, busy=1.
  - IDLE: start=1 with stage >= LOG2N is ignored; the FSM stays in IDLE.
  - RUN: issue one address per enabled cycle. After issuing k=K-1 → DRAIN.
  - DRAIN: wait until the last twiddle is accepted (tw_valid & tw_ready & tw_last) → IDLE, busy=0 on the following cycle.
- Pipeline: address register → ROM data register → output register, with per-stage valid bits.
  - Global enable en = !tw_valid | tw_ready. All pipeline registers and the counter advance only when en=1.
  - When tw_ready=0 with tw_valid=1, the outputs hold stable and no twiddle is lost or duplicated.
- Latency: with start sampled at edge t and tw_ready held at 1, the first tw_valid rises after edge t+3. Afterwards one twiddle is produced per cycle, with no bubbles.
- Handshake rules:
  - tw_last=1 exactly on k=K-1 and is held with the data.
  - tw_valid never drops while tw_ready=0.
- Edge cases:
  - start while busy=1 is ignored, and stage/inverse are not relatched.
  - Stage LOG2N-1 gives K=1: one twiddle (1,0) with tw_last=1.
  - Back-to-back sequences: start may be asserted in the cycle busy returns to 0.

Decomposition:
- fft_defs.vh: TWIDDLE_WIDTH default, Q1.15 scale constant (32767), and the stage-width define.
- One sub-module, twiddle_rom: a quarter-wave sine ROM, synchronous read, depth N/4+1, contents generated at elaboration or from a mem file.
- twiddle_gen contains the FSM, counter, address/sign mapping and output pipeline.

Test Plan:
- N=16, stage=0, inverse=0, tw_ready=1 → 8 twiddles, (real,imag) for m=0..7:
  - m=0..3: (32767,0), (30273,-12539), (23170,-23170), (12539,-30273)
  - m=4..7: (0,-32767), (-12539,-30273), (-23170,-23170), (-30273,-12539)
  - tw_last=1 only on m=7; first valid after edge t+3.
- N=16, stage=2, inverse=1 → 2 twiddles (32767,0) then (0,+32767), tw_last on the second; busy returns to 0 after acceptance.
- stage=0 with tw_ready toggling 1,0,0,1,... → outputs hold during stalls; the sequence matches the first test exactly, with no drops or duplicates.
- start with stage=4 (N=16) → no tw_valid and busy stays 0. start pulsed mid-sequence → ignored, count unchanged.
- rst_n=0 for one cycle after the 3rd twiddle of stage 0 → tw_valid=busy=tw_last=0 next cycle; a new start reproduces the full sequence from m=0.
- stage=3 (K=1) back-to-back with stage=1 (start asserted the cycle busy falls) → (32767,0) with tw_last, then the 4 twiddles for m=0,2,4,6.
